// File: rtl/reflet_float_acc_pkg.sv
// Shared float helpers and accumulator state encodings.
// Sequencers import this to size float fields and to decode busy/state.
package reflet_float_acc_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACC  = ST_ACC,
        DONE = ST_DONE
    } acc_state_t;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

endpackage

// File: rtl/reflet_float_acc_add.sv
// Combinational float adder/subtractor, truncating, no NaN handling.
// Ports: in1, in2 operands; enable_add/enable_sub select op; out result.
import reflet_float_acc_pkg::*;

module reflet_float_add #(
    parameter int float_size = 32
) (
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    input  logic                  enable_add,
    input  logic                  enable_sub,
    output logic [float_size-1:0] out
);
    localparam int ms = mantissa_size(float_size);
    localparam int es = exponent_size(float_size);
    localparam int sw = ms + 1;
    localparam logic [es-1:0] emax = '1;
    localparam logic [es-1:0] sw_e = es'(sw);

    logic          sa, sb, sh, sl;
    logic [es-1:0] ea, eb, eh, el, d, lz;
    logic [sw-1:0] ma, mb, mh, ml, sal, diff, norm;
    logic [sw:0]   sum;
    logic          found;

    always_comb begin
        out   = '0;
        lz    = '0;
        found = 1'b0;
        norm  = '0;
        sa = in1[float_size-1];
        sb = in2[float_size-1] ^ (enable_sub & ~enable_add);
        ea = in1[float_size-2 -: es];
        eb = in2[float_size-2 -: es];
        // Hidden bit is clear for a zero exponent.
        ma = {|ea, in1[ms-1:0]};
        mb = {|eb, in2[ms-1:0]};
        // Magnitude ordering of IEEE words is plain unsigned ordering.
        if (in1[float_size-2:0] >= in2[float_size-2:0]) begin
            sh = sa; eh = ea; mh = ma;
            sl = sb; el = eb; ml = mb;
        end else begin
            sh = sb; eh = eb; mh = mb;
            sl = sa; el = ea; ml = ma;
        end
        d    = eh - el;
        sal  = (d >= sw_e) ? '0 : (ml >> d);
        sum  = {1'b0, mh} + {1'b0, sal};
        diff = mh - sal;
        for (int i = sw - 1; i >= 0; i--) begin
            if (!found && diff[i]) begin
                lz    = es'(sw - 1 - i);
                found = 1'b1;
            end
        end
        if (eh == emax) begin
            out = {sh, emax, {ms{1'b0}}};
        end else if (sh == sl) begin
            if (sum[sw]) begin
                if (eh == emax - 1'b1)
                    out = {sh, emax, {ms{1'b0}}};
                else
                    out = {sh, eh + 1'b1, sum[ms:1]};
            end else if (sum != '0) begin
                out = {sh, eh, sum[ms-1:0]};
            end
        end else if (found && (eh > lz)) begin
            // Exact cancellation and underflow both flush to +0.
            norm = diff << lz;
            out  = {sh, eh - lz, norm[ms-1:0]};
        end
    end

endmodule

// File: rtl/reflet_float_acc.sv
// Streaming float accumulator: folds length inputs with + or - into acc.
// Ports: start/length/sub_mode, in_valid/in_ready/in_data, out_* , busy.
import reflet_float_acc_pkg::*;

module reflet_float_acc #(
    parameter int float_size = 32,
    parameter int count_size = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [count_size-1:0] length,
    input  logic                  sub_mode,
    input  logic                  in_valid,
    input  logic [float_size-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [float_size-1:0] out_data,
    input  logic                  out_ready,
    output logic                  out_inf,
    output logic                  busy
);
    localparam int es = exponent_size(float_size);

    acc_state_t            state, state_n;
    logic [float_size-1:0] acc, acc_n, add_out;
    logic [count_size-1:0] remaining, remaining_n;
    logic                  mode, mode_n;
    logic                  first, first_n;
    logic                  inf_q;

    reflet_float_add #(
        .float_size(float_size)
    ) u_add (
        .in1       (acc),
        .in2       (in_data),
        .enable_add(~mode),
        .enable_sub(mode),
        .out       (add_out)
    );

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        remaining_n = remaining;
        mode_n      = mode;
        first_n     = first;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        remaining_n = length;
                        mode_n      = sub_mode;
                        first_n     = 1'b1;
                        state_n     = ACC;
                    end else begin
                        acc_n   = '0;
                        state_n = DONE;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    // First element bypasses the adder to stay exact.
                    acc_n       = first ? in_data : add_out;
                    remaining_n = remaining - count_size'(1);
                    first_n     = 1'b0;
                    if (remaining == count_size'(1))
                        state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            mode      <= 1'b0;
            first     <= 1'b0;
            inf_q     <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            remaining <= remaining_n;
            mode      <= mode_n;
            first     <= first_n;
            inf_q     <= &acc_n[float_size-2 -: es];
        end
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = acc;
    assign out_inf   = inf_q;

endmodule

// File: tb/tb_reflet_float_acc.sv
// Self-checking bench for reflet_float_acc: directed and random runs
// compared against an integer-arithmetic reference of the fold.
module tb_reflet_float_acc;

    logic        clk = 1'b0;
    logic        reset, start, sub_mode, in_valid, out_ready;
    logic [7:0]  length;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_inf, busy;
    logic [31:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat;
    logic [31:0] beats[$];

    reflet_float_acc dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .length   (length),
        .sub_mode (sub_mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_inf  (out_inf),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact IEEE single encoding of a small integer.
    function automatic logic [31:0] to_float(input int v);
        int mag, p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 30; i++)
            if (mag >= (1 << i)) p = i;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((mag << (23 - p)) & 32'h7FFFFF);
        return r;
    endfunction

    task automatic run(input int n, input bit sub, input int gap,
                       output int l);
        int s;
        @(negedge clk);
        start = 1'b1; length = 8'(n); sub_mode = sub; s = cyc;
        @(negedge clk);
        start = 1'b0; length = 8'd0; sub_mode = 1'b0;
        for (int i = 0; i < beats.size(); i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    chk("in_ready_gap", 32'(in_ready), 32'd1);
                    @(negedge clk);
                end
            end
            chk("in_ready_beat", 32'(in_ready), 32'd1);
            in_valid = 1'b1; in_data = beats[i];
            @(negedge clk);
            in_valid = 1'b0; in_data = 32'h0;
        end
        l = -1;
        for (int k = 0; k < 60; k++) begin
            if (out_valid) begin
                l = cyc - s;
                break;
            end
            @(negedge clk);
        end
        if (l < 0) chk("done_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_out(input logic [31:0] exp, input bit exp_inf,
                              input int hold);
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", out_data, exp);
        chk("out_inf", 32'(out_inf), 32'(exp_inf));
        chk("busy_done", 32'(busy), 32'd1);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (h == 2) begin start = 1'b1; length = 8'd5; end
            @(negedge clk);
            start = 1'b0; length = 8'd0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("valid_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n, gap, v, total;
        bit sub;
        reset = 1'b1; start = 1'b0; sub_mode = 1'b0; length = 8'd0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_inf", 32'(out_inf), 32'd0);
        reset = 1'b0;

        beats = '{32'h3F800000, 32'h40000000, 32'h40400000};
        run(3, 1'b0, 0, lat);
        chk("add_latency", 32'(lat), 32'd4);
        finish_out(32'h40C00000, 1'b0, 0);

        beats = '{32'h40C00000, 32'h40000000, 32'h3F800000};
        run(3, 1'b1, 2, lat);
        finish_out(32'h40400000, 1'b0, 5);

        beats = '{32'hC0000000};
        run(1, 1'b1, 0, lat);
        chk("len1_latency", 32'(lat), 32'd2);
        finish_out(32'hC0000000, 1'b0, 0);

        beats.delete();
        run(0, 1'b0, 0, lat);
        chk("len0_latency", 32'(lat), 32'd1);
        finish_out(32'h0, 1'b0, 0);

        beats = '{32'h7F7FFFFF, 32'h7F7FFFFF};
        run(2, 1'b0, 0, lat);
        finish_out(32'h7F800000, 1'b1, 0);

        @(negedge clk);
        start = 1'b1; length = 8'd3; sub_mode = 1'b0;
        @(negedge clk);
        start = 1'b0; length = 8'd0;
        in_valid = 1'b1; in_data = 32'h3F800000;
        @(negedge clk);
        in_valid = 1'b0; in_data = 32'h0;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_acc", out_data, 32'h3F800000);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_out_inf", 32'(out_inf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        beats = '{32'h3F800000, 32'h3F800000};
        run(2, 1'b0, 0, lat);
        finish_out(32'h40000000, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            n   = int'($urandom_range(1, 20));
            sub = 1'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 2));
            beats.delete();
            total = 0;
            for (int i = 0; i < n; i++) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                beats.push_back(to_float(v));
                if (i == 0)   total = v;
                else if (sub) total = total - v;
                else          total = total + v;
            end
            run(n, sub, gap, lat);
            if (gap == 0) chk("rand_latency", 32'(lat), 32'(n + 1));
            finish_out(to_float(total), 1'b0, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
